// File: rtl/backprop_pkg.sv
// Shared definitions for the backpropagation training-step controller and the
// error stage: state encodings and default bus widths.
package backprop_pkg;

    localparam int LAYER_ADDR_WIDTH_DEF = 2;
    localparam int SAMPLE_ADDR_SIZE_DEF = 10;

    localparam logic [2:0] IDLE_ENC = 3'd0;
    localparam logic [2:0] FWD_ENC  = 3'd1;
    localparam logic [2:0] ERR_ENC  = 3'd2;
    localparam logic [2:0] UPD_ENC  = 3'd3;
    localparam logic [2:0] NEXT_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = IDLE_ENC,
        ST_FWD  = FWD_ENC,
        ST_ERR  = ERR_ENC,
        ST_UPD  = UPD_ENC,
        ST_NEXT = NEXT_ENC
    } state_t;

endpackage

// File: rtl/backprop_sequencer.sv
// Training-step controller: forward pass per sample, then error/update stages
// walking layers from LAYER_MAX down to 1, for SAMPLE_NUM samples.
module backprop_sequencer
    import backprop_pkg::*;
#(
    parameter int LAYER_ADDR_WIDTH = LAYER_ADDR_WIDTH_DEF,
    parameter int LAYER_MAX        = 3,
    parameter int SAMPLE_ADDR_SIZE = SAMPLE_ADDR_SIZE_DEF,
    parameter int SAMPLE_NUM       = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        fwd_start,
    input  logic                        fwd_done,
    output logic                        err_start,
    input  logic                        err_done,
    output logic                        upd_start,
    input  logic                        upd_done,
    output logic [LAYER_ADDR_WIDTH-1:0] layer,
    output logic [SAMPLE_ADDR_SIZE-1:0] sample_index,
    output logic                        busy,
    output logic                        run_done
);

    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ZERO  = {LAYER_ADDR_WIDTH{1'b0}};
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP   = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_ZERO = {SAMPLE_ADDR_SIZE{1'b0}};
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_ONE  = SAMPLE_ADDR_SIZE'(1);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_LAST = SAMPLE_ADDR_SIZE'(SAMPLE_NUM - 1);

    state_t                        state_r;
    state_t                        state_nx_s;
    logic [LAYER_ADDR_WIDTH-1:0]   layer_nx_s;
    logic [SAMPLE_ADDR_SIZE-1:0]   sample_nx_s;
    logic                          fwd_start_nx_s;
    logic                          err_start_nx_s;
    logic                          upd_start_nx_s;
    logic                          run_done_nx_s;
    logic                          busy_nx_s;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nx_s     = state_r;
        layer_nx_s     = layer;
        sample_nx_s    = sample_index;
        fwd_start_nx_s = 1'b0;
        err_start_nx_s = 1'b0;
        upd_start_nx_s = 1'b0;
        run_done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sample_nx_s    = SAMPLE_ZERO;
                    layer_nx_s     = LAYER_ZERO;
                    fwd_start_nx_s = 1'b1;
                    state_nx_s     = ST_FWD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (fwd_done) begin
                    layer_nx_s     = LAYER_TOP;
                    err_start_nx_s = 1'b1;
                    state_nx_s     = ST_ERR;
                end else begin
                    state_nx_s = ST_FWD;
                end
            end
            ST_ERR: begin
                if (err_done) begin
                    upd_start_nx_s = 1'b1;
                    state_nx_s     = ST_UPD;
                end else begin
                    state_nx_s = ST_ERR;
                end
            end
            ST_UPD: begin
                if (upd_done) begin
                    state_nx_s = ST_NEXT;
                end else begin
                    state_nx_s = ST_UPD;
                end
            end
            ST_NEXT: begin
                // Layer 1 is the last layer with weights; below it the sample is finished.
                if (layer > LAYER_ONE) begin
                    layer_nx_s     = layer - LAYER_ONE;
                    err_start_nx_s = 1'b1;
                    state_nx_s     = ST_ERR;
                end else if (sample_index < SAMPLE_LAST) begin
                    sample_nx_s    = sample_index + SAMPLE_ONE;
                    layer_nx_s     = LAYER_ZERO;
                    fwd_start_nx_s = 1'b1;
                    state_nx_s     = ST_FWD;
                end else begin
                    run_done_nx_s = 1'b1;
                    sample_nx_s   = SAMPLE_ZERO;
                    layer_nx_s    = LAYER_ZERO;
                    state_nx_s    = ST_IDLE;
                end
            end
            default: begin
                sample_nx_s = SAMPLE_ZERO;
                layer_nx_s  = LAYER_ZERO;
                state_nx_s  = ST_IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            layer        <= LAYER_ZERO;
            sample_index <= SAMPLE_ZERO;
            fwd_start    <= 1'b0;
            err_start    <= 1'b0;
            upd_start    <= 1'b0;
            run_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            layer        <= layer_nx_s;
            sample_index <= sample_nx_s;
            fwd_start    <= fwd_start_nx_s;
            err_start    <= err_start_nx_s;
            upd_start    <= upd_start_nx_s;
            run_done     <= run_done_nx_s;
            busy         <= busy_nx_s;
        end
    end

endmodule

// File: tb/tb_backprop_sequencer.sv
// Scoreboard bench: two sequencers (LAYER_MAX=3/SAMPLE_NUM=2 and 1/1) with
// done responders; every output pulse is matched against a queue of expected events.
module tb_backprop_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, fwd_start, fwd_done, err_start, err_done, upd_start, upd_done;
    logic [1:0] busy, run_done;
    logic [1:0] layer_s [2];
    logic [9:0] sample_s [2];

    logic [1:0] tie_hi, inj_err, inj_upd, fwd_r, err_r, upd_r;
    int         vectors = 0;
    int         miscompares = 0;
    logic [13:0] exp_q [2][$];

    assign fwd_done = tie_hi | fwd_r;
    assign err_done = tie_hi | err_r | inj_err;
    assign upd_done = tie_hi | upd_r | inj_upd;

    always #5 clk = ~clk;

    backprop_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(3), .SAMPLE_ADDR_SIZE(10), .SAMPLE_NUM(2)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .fwd_start(fwd_start[0]), .fwd_done(fwd_done[0]),
        .err_start(err_start[0]), .err_done(err_done[0]),
        .upd_start(upd_start[0]), .upd_done(upd_done[0]),
        .layer(layer_s[0]), .sample_index(sample_s[0]),
        .busy(busy[0]), .run_done(run_done[0])
    );

    backprop_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(1), .SAMPLE_ADDR_SIZE(10), .SAMPLE_NUM(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .fwd_start(fwd_start[1]), .fwd_done(fwd_done[1]),
        .err_start(err_start[1]), .err_done(err_done[1]),
        .upd_start(upd_start[1]), .upd_done(upd_done[1]),
        .layer(layer_s[1]), .sample_index(sample_s[1]),
        .busy(busy[1]), .run_done(run_done[1])
    );

    function automatic logic [13:0] mk(input logic [1:0] kind, input logic [1:0] lay, input logic [9:0] smp);
        return {kind, lay, smp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Event kinds: 0 fwd_start, 1 err_start, 2 upd_start, 3 run_done.
    task automatic mon_ev(input int d, input logic [13:0] ev);
        logic [13:0] e;
        vectors++;
        if (exp_q[d].size() == 0) begin
            miscompares++;
            $display("FAIL dut%0d_event: got kind=%0d layer=%0d sample=%0d, required no event",
                     d, ev[13:12], ev[11:10], ev[9:0]);
        end else begin
            e = exp_q[d].pop_front();
            if (ev !== e) begin
                miscompares++;
                $display("FAIL dut%0d_event: got kind=%0d layer=%0d sample=%0d, required kind=%0d layer=%0d sample=%0d",
                         d, ev[13:12], ev[11:10], ev[9:0], e[13:12], e[11:10], e[9:0]);
            end
        end
    endtask

    task automatic push_run(input int d, input int lmax, input int snum);
        for (int s = 0; s < snum; s++) begin
            exp_q[d].push_back(mk(2'd0, 2'd0, 10'(s)));
            for (int l = lmax; l >= 1; l--) begin
                exp_q[d].push_back(mk(2'd1, 2'(l), 10'(s)));
                exp_q[d].push_back(mk(2'd2, 2'(l), 10'(s)));
            end
        end
        exp_q[d].push_back(mk(2'd3, 2'd0, 10'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int budget, output int cycles);
        cycles = 0;
        while (run_done[d] !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (run_done[d] !== 1'b1) begin
            check($sformatf("dut%0d_run_done_timeout", d), 32'd0, 32'd1);
        end
    endtask

    // Monitor: every pulse seen at the falling edge is matched against the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fwd_start[d] === 1'b1) mon_ev(d, mk(2'd0, layer_s[d], sample_s[d]));
            if (err_start[d] === 1'b1) mon_ev(d, mk(2'd1, layer_s[d], sample_s[d]));
            if (upd_start[d] === 1'b1) mon_ev(d, mk(2'd2, layer_s[d], sample_s[d]));
            if (run_done[d] === 1'b1)  mon_ev(d, mk(2'd3, layer_s[d], sample_s[d]));
        end
    end

    // Responders: a done pulse two cycles after each start pulse.
    initial begin
        int cnt [2][3];
        logic [2:0] pl, dn;
        fwd_r = 2'b00;
        err_r = 2'b00;
        upd_r = 2'b00;
        for (int d = 0; d < 2; d++) for (int s = 0; s < 3; s++) cnt[d][s] = 0;
        forever begin
            tick();
            for (int d = 0; d < 2; d++) begin
                pl = {upd_start[d], err_start[d], fwd_start[d]};
                for (int s = 0; s < 3; s++) begin
                    if (rst) begin
                        cnt[d][s] = 0;
                        dn[s] = 1'b0;
                    end else if (pl[s]) begin
                        cnt[d][s] = 2;
                        dn[s] = 1'b0;
                    end else if (cnt[d][s] > 0) begin
                        cnt[d][s]--;
                        dn[s] = (cnt[d][s] == 0);
                    end else begin
                        dn[s] = 1'b0;
                    end
                end
                fwd_r[d] = dn[0];
                err_r[d] = dn[1];
                upd_r[d] = dn[2];
            end
        end
    end

    initial begin
        int n;
        int guard;
        rst = 1'b1;
        start = 2'b00;
        tie_hi = 2'b00;
        inj_err = 2'b00;
        inj_upd = 2'b00;
        repeat (3) tick();
        check("reset_pulses_busy", {fwd_start, err_start, upd_start, run_done, busy}, 32'd0);
        check("reset_layer0", layer_s[0], 32'd0);
        check("reset_sample0", sample_s[0], 32'd0);
        rst = 1'b0;
        tick();

        // Full run with 2-cycle responders.
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t1_fwd_start_cycle1", fwd_start[0], 32'd1);
        check("t1_busy", busy[0], 32'd1);
        wait_done(0, 200, n);
        check("t1_busy_at_run_done", busy[0], 32'd0);
        check("t1_sample_at_run_done", sample_s[0], 32'd0);
        tick();
        tick();

        // Zero-latency responders: fixed run length.
        tie_hi[0] = 1'b1;
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t2_fwd_start", fwd_start[0], 32'd1);
        wait_done(0, 100, n);
        check("t2_run_cycles", n + 1, 32'd21);

        // start in the run_done cycle launches the next run immediately.
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t6_fwd_start_after_run_done", fwd_start[0], 32'd1);
        check("t6_busy", busy[0], 32'd1);
        wait_done(0, 100, n);
        tie_hi[0] = 1'b0;
        tick();
        tick();

        // Spurious done inputs during FWD and start held high mid-run.
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        inj_err[0] = 1'b1;
        inj_upd[0] = 1'b1;
        tick();
        check("t3_no_err_upd_pulse", {err_start[0], upd_start[0], fwd_start[0]}, 32'd0);
        check("t3_layer_stable", layer_s[0], 32'd0);
        tick();
        check("t3_no_err_upd_pulse2", {err_start[0], upd_start[0]}, 32'd0);
        check("t3_sample_stable", sample_s[0], 32'd0);
        inj_err[0] = 1'b0;
        inj_upd[0] = 1'b0;
        repeat (18) tick();
        start[0] = 1'b0;
        wait_done(0, 200, n);
        tick();
        tick();

        // Reset while in UPD at layer 2, with start asserted alongside rst.
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        guard = 0;
        while (!(upd_start[0] === 1'b1 && layer_s[0] == 2'd2) && guard < 100) begin
            tick();
            guard++;
        end
        check("t4_reach_upd_layer2", guard < 100, 32'd1);
        rst = 1'b1;
        start[0] = 1'b1;
        tick();
        exp_q[0].delete();
        check("t4_outputs_cleared", {fwd_start[0], err_start[0], upd_start[0], run_done[0], busy[0]}, 32'd0);
        check("t4_layer_cleared", layer_s[0], 32'd0);
        check("t4_sample_cleared", sample_s[0], 32'd0);
        rst = 1'b0;
        start[0] = 1'b0;
        tick();
        check("t4_start_with_rst_ignored", busy[0], 32'd0);
        push_run(0, 3, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("t4_restart_fwd", fwd_start[0], 32'd1);
        check("t4_restart_sample", sample_s[0], 32'd0);
        wait_done(0, 200, n);

        // Single layer, single sample.
        push_run(1, 1, 1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("t5_fwd_start", fwd_start[1], 32'd1);
        wait_done(1, 100, n);
        check("t5_busy_at_run_done", busy[1], 32'd0);

        repeat (3) tick();
        check("drain_dut0_queue", exp_q[0].size(), 32'd0);
        check("drain_dut1_queue", exp_q[1].size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
